// File: rtl/multi_button_shaper.sv
// Multi-channel push-button front end: synchronise, debounce, and turn each
// accepted press (and optional auto-repeat) into a single-cycle strobe.
module multi_button_shaper #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] button_IN,
  input  logic                controlFlag,
  input  logic                repeat_en,
  output logic [CHANNELS-1:0] button_OUT,
  output logic [CHANNELS-1:0] button_held,
  output logic                any_pulse
);

  localparam int DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RepW   = $clog2(RepMax + 1);

  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

  localparam logic [1:0] StIdle        = 2'd0;
  localparam logic [1:0] StHeldNoPulse = 2'd1;
  localparam logic [1:0] StHeld        = 2'd2;
  localparam logic [1:0] StRepeat      = 2'd3;

  for (genvar g = 0; g < CHANNELS; g++) begin : gChan
    logic            syncMeta_q;
    logic            syncOut_q;
    logic            db_q, db_d;
    logic [DbW-1:0]  dbCount_q, dbCount_d;
    logic [1:0]      state_q, state_d;
    logic [RepW-1:0] repCount_q, repCount_d;
    logic            pulse_q, pulse_d;
    logic            held_q;

    always_comb begin
      db_d      = db_q;
      dbCount_d = '0;
      if (syncOut_q != db_q) begin
        if (dbCount_q == DbLast) begin
          db_d = ~db_q;
        end else begin
          dbCount_d = dbCount_q + 1'b1;
        end
      end
    end

    // Release is judged on db_d so a release that debounces on the same edge
    // a repeat is due suppresses that repeat.
    always_comb begin
      state_d    = state_q;
      repCount_d = repCount_q;
      pulse_d    = 1'b0;
      case (state_q)
        StIdle: begin
          if (!db_q) begin
            repCount_d = '0;
            if (controlFlag) begin
              state_d = StHeld;
              pulse_d = 1'b1;
            end else begin
              state_d = StHeldNoPulse;
            end
          end
        end
        StHeldNoPulse: begin
          if (db_d) state_d = StIdle;
        end
        StHeld: begin
          if (db_d) begin
            state_d    = StIdle;
            repCount_d = '0;
          end else if (!repeat_en) begin
            repCount_d = '0;
          end else if (repCount_q == DelayLast) begin
            state_d    = StRepeat;
            repCount_d = '0;
            pulse_d    = 1'b1;
          end else begin
            repCount_d = repCount_q + 1'b1;
          end
        end
        StRepeat: begin
          if (db_d) begin
            state_d    = StIdle;
            repCount_d = '0;
          end else if (!repeat_en) begin
            state_d    = StHeld;
            repCount_d = '0;
          end else if (repCount_q == RateLast) begin
            repCount_d = '0;
            pulse_d    = 1'b1;
          end else begin
            repCount_d = repCount_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        syncMeta_q <= 1'b1;
        syncOut_q  <= 1'b1;
        db_q       <= 1'b1;
        dbCount_q  <= '0;
        state_q    <= StIdle;
        repCount_q <= '0;
        pulse_q    <= 1'b0;
        held_q     <= 1'b0;
      end else begin
        syncMeta_q <= button_IN[g];
        syncOut_q  <= syncMeta_q;
        db_q       <= db_d;
        dbCount_q  <= dbCount_d;
        state_q    <= state_d;
        repCount_q <= repCount_d;
        pulse_q    <= pulse_d;
        held_q     <= ~db_q;
      end
    end

    assign button_OUT[g]  = pulse_q;
    assign button_held[g] = held_q;
  end

  assign any_pulse = |button_OUT;

endmodule

// File: tb/tb_multi_button_shaper.sv
// Directed bench for multi_button_shaper: expected strobe edges are queued when
// buttons are driven and matched against button_OUT/any_pulse every cycle.
module tb_multi_button_shaper;

  localparam int CH = 4;
  localparam int DC = 4;
  localparam int RD = 16;
  localparam int RR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] buttonIn = '1;
  logic          controlFlag = 1'b1;
  logic          repeatEn = 1'b0;
  logic [CH-1:0] button_OUT;
  logic [CH-1:0] button_held;
  logic          any_pulse;

  multi_button_shaper #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .button_IN(buttonIn), .controlFlag(controlFlag),
    .repeat_en(repeatEn), .button_OUT(button_OUT), .button_held(button_held),
    .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  int edgeCount = 0;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  typedef struct {
    int ch;
    int edgeNum;
  } exp_t;
  exp_t expQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h at edge %0d", tag, observed, expected, edgeCount);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  task automatic expectPulse(input int ch, input int e);
    expQ.push_back('{ch: ch, edgeNum: e});
  endtask

  task automatic applyStimulus(input int ch, input logic level);
    buttonIn[ch] = level;
  endtask

  // Scoreboard: each cycle, the strobes due on this edge are exactly the ones queued.
  logic [CH-1:0] expVec;
  always @(negedge clk) begin
    expVec = '0;
    for (int k = expQ.size() - 1; k >= 0; k--) begin
      if (expQ[k].edgeNum == edgeCount) begin
        expVec[2'(expQ[k].ch)] = 1'b1;
        expQ.delete(k);
      end
    end
    checkOutput("button_OUT", 32'(button_OUT), 32'(expVec));
    checkOutput("any_pulse", 32'(any_pulse), 32'(|expVec));
  end

  initial begin
    int t;
    int p;
    int relEdge;
    int releaseAt;

    $display("[TB] starting multi_button_shaper bench");
    rst = 1'b1;
    waitCycles(3);
    checkOutput("reset button_OUT", 32'(button_OUT), 32'(0));
    checkOutput("reset button_held", 32'(button_held), 32'(0));
    checkOutput("reset any_pulse", 32'(any_pulse), 32'(0));
    rst = 1'b0;
    waitCycles(5);

    // clean press on channel 0
    t = edgeCount;
    expectPulse(0, t + DC + 3);
    applyStimulus(0, 1'b0);
    waitCycles(DC + 2);
    checkOutput("held0 before debounce", 32'(button_held[0]), 32'(0));
    tick();
    checkOutput("held0 after debounce", 32'(button_held[0]), 32'(1));
    checkOutput("held others idle", 32'(button_held[3:1]), 32'(0));
    waitCycles(40 - (DC + 3));
    applyStimulus(0, 1'b1);
    waitCycles(DC + 2);
    checkOutput("held0 before release", 32'(button_held[0]), 32'(1));
    tick();
    checkOutput("held0 released", 32'(button_held[0]), 32'(0));
    waitCycles(5);

    // bouncing channel 1: 2-sample glitches must be ignored
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, ((i % 4) < 2) ? 1'b0 : 1'b1);
      tick();
    end
    checkOutput("held1 after bounce", 32'(button_held[1]), 32'(0));
    t = edgeCount;
    expectPulse(1, t + DC + 3);
    applyStimulus(1, 1'b0);
    waitCycles(DC + 3);
    checkOutput("held1 stable press", 32'(button_held[1]), 32'(1));
    waitCycles(10);
    applyStimulus(1, 1'b1);
    waitCycles(DC + 8);

    // auto-repeat on channel 2, release debouncing exactly when a repeat is due
    repeatEn = 1'b1;
    t = edgeCount;
    p = t + DC + 3;
    relEdge = p + RD + 6 * RR;
    expectPulse(2, p);
    for (int e = p + RD; e < relEdge; e += RR) expectPulse(2, e);
    applyStimulus(2, 1'b0);
    releaseAt = relEdge - DC - 2;
    waitCycles(releaseAt - t);
    applyStimulus(2, 1'b1);
    waitCycles(DC + 8);
    checkOutput("held2 after repeat release", 32'(button_held[2]), 32'(0));
    repeatEn = 1'b0;

    // press accepted only if controlFlag is high when db falls
    controlFlag = 1'b0;
    applyStimulus(3, 1'b0);
    waitCycles(DC + 3 + 10);
    controlFlag = 1'b1;
    waitCycles(15);
    checkOutput("held3 gated press", 32'(button_held[3]), 32'(1));
    applyStimulus(3, 1'b1);
    waitCycles(DC + 8);
    checkOutput("held3 gated release", 32'(button_held[3]), 32'(0));
    t = edgeCount;
    expectPulse(3, t + DC + 3);
    applyStimulus(3, 1'b0);
    waitCycles(DC + 10);
    applyStimulus(3, 1'b1);
    waitCycles(DC + 8);

    // simultaneous presses on channels 0 and 3
    t = edgeCount;
    expectPulse(0, t + DC + 3);
    expectPulse(3, t + DC + 3);
    applyStimulus(0, 1'b0);
    applyStimulus(3, 1'b0);
    waitCycles(DC + 3);
    checkOutput("simultaneous button_OUT", 32'(button_OUT), 32'(4'b1001));
    checkOutput("simultaneous any_pulse", 32'(any_pulse), 32'(1));
    tick();
    checkOutput("simultaneous one cycle", 32'(button_OUT), 32'(0));
    waitCycles(5);
    applyStimulus(0, 1'b1);
    applyStimulus(3, 1'b1);
    waitCycles(DC + 8);

    // reset while a repeat strobe is high, button kept held
    repeatEn = 1'b1;
    t = edgeCount;
    p = t + DC + 3;
    expectPulse(2, p);
    expectPulse(2, p + RD);
    expectPulse(2, p + RD + RR);
    applyStimulus(2, 1'b0);
    waitCycles(p + RD + RR - t);
    checkOutput("repeat pulse before reset", 32'(button_OUT[2]), 32'(1));
    rst = 1'b1;
    tick();
    checkOutput("mid reset button_OUT", 32'(button_OUT), 32'(0));
    checkOutput("mid reset button_held", 32'(button_held), 32'(0));
    checkOutput("mid reset any_pulse", 32'(any_pulse), 32'(0));
    t = edgeCount;
    expectPulse(2, t + DC + 3);
    rst = 1'b0;
    waitCycles(DC + 2);
    checkOutput("held2 before fresh press", 32'(button_held[2]), 32'(0));
    tick();
    checkOutput("held2 fresh press", 32'(button_held[2]), 32'(1));
    waitCycles(2);
    applyStimulus(2, 1'b1);
    waitCycles(DC + 8);
    repeatEn = 1'b0;
    waitCycles(5);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multi_button_shaper.md
# multi_button_shaper

Parametrised, multi-channel front end for the board's push buttons. Each channel synchronises and debounces one active-low button and emits single-cycle pulses. A channel pulses once per press and can optionally auto-repeat while the button is held. The block sits between the raw button pins and the control FSMs, and supplies the one-cycle `button_OUT` strobes those FSMs consume.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised samples that must disagree with the debounced level before it flips (≥1).
- `REPEAT_DELAY`, 16: cycles from the initial press pulse to the first repeat pulse (≥2).
- `REPEAT_RATE`, 8: cycles between successive repeat pulses (≥2).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `button_IN` input CHANNELS: raw buttons, asynchronous, active-low (0 = pressed).
- `controlFlag` input 1: press-accept enable, shared by all channels.
- `repeat_en` input 1: auto-repeat enable, sampled every cycle.
- `button_OUT` output CHANNELS: one-cycle active-high pulse per accepted press or repeat.
- `button_held` output CHANNELS: debounced pressed level, 1 = pressed.
- `any_pulse` output 1: OR of `button_OUT`, in the same cycle.

## Operation
- **Per-channel datapath:**
  - 2-flop synchroniser, reset value 1 (released).
  - Debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Debounced level `db`, reset value 1.
  - Pulse FSM with repeat counter, width `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`.
- **Debounce:**
  - Counter clears whenever the synchronised sample equals `db`; otherwise it increments.
  - On the DEBOUNCE_CYCLES-th consecutive mismatch, `db` toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes `db`.
- **FSM states:** IDLE, HELD_NOPULSE, HELD, REPEAT.
  - IDLE: on the `db` falling edge, go to HELD if `controlFlag`=1 and assert `button_OUT` next cycle. If `controlFlag`=0, go to HELD_NOPULSE with no pulse.
  - HELD_NOPULSE: wait for `db`=1, then return to IDLE. Raising `controlFlag` while held never generates a pulse, so the button must be released and pressed again.
  - HELD: repeat counter counts from the press pulse. If `repeat_en`=1 and the count reaches REPEAT_DELAY, pulse, clear the counter and go to REPEAT. If `repeat_en`=0, the counter holds at 0. On `db`=1, go to IDLE.
  - REPEAT: pulse every REPEAT_RATE cycles while `repeat_en`=1 and `db`=0. If `repeat_en` drops, go to HELD with the counter cleared. On `db`=1, go to IDLE.
- **Pulse gating:** `controlFlag` gates only press acceptance. Repeats continue while it is low.
- `button_held[i]` = ~`db[i]`.
- Channels are fully independent. Any number of `button_OUT` bits may be high in the same cycle.
- **Reset and pulse shape:**
  - While `rst` is high, every output is 0, all FSMs are IDLE, and all counters are 0.
  - A button held low through reset deassertion is treated as a fresh press after debounce.
  - No pulse is ever longer than one cycle. Release never pulses.

## Timing
- Edge 0 is the first rising edge that samples `button_IN[i]`=0, with the button stable thereafter.
  - `db` falls at edge 1+DEBOUNCE_CYCLES.
  - `button_OUT[i]` is high for exactly the cycle after edge 2+DEBOUNCE_CYCLES, and low otherwise.
- Release latency is symmetrical: `button_held` falls at edge 2+DEBOUNCE_CYCLES after the first high sample.
- The first repeat pulse is REPEAT_DELAY cycles after the press pulse. Each later repeat pulse is REPEAT_RATE cycles after the previous one.
- If release debounces in the same cycle a repeat is due, release wins and no pulse is issued.
- `controlFlag` is sampled in the cycle `db` falls, and only that sample matters.
- `any_pulse` is combinational from registered `button_OUT`, with no added latency.
- If `rst` is asserted mid-pulse, `button_OUT` is 0 on the next cycle.

## Test plan
- **Clean press:** CHANNELS=4, DEBOUNCE_CYCLES=4, `controlFlag`=1, `repeat_en`=0; hold `button_IN[0]`=0 for 40 cycles. Expect `button_OUT[0]` high only in the cycle after edge 6, and `button_held[0]` rising at edge 6. Other channels stay 0.
- **Bounce:** toggle `button_IN[1]` low/high every 2 cycles for 20 cycles, then hold low. Expect no pulse during the bounce, then exactly one pulse DEBOUNCE_CYCLES+2 edges after the hold begins.
- **Auto-repeat:** `repeat_en`=1, REPEAT_DELAY=16, REPEAT_RATE=8; hold channel 2 for 60 cycles after the press pulse at cycle P. Expect pulses at P, P+16, P+24, P+32, ... and none after release debounces.
- **Enable gating:**
  - `controlFlag`=0 at the press, raised 10 cycles later: expect no pulse and `button_held`=1.
  - Release, then press again with `controlFlag`=1: expect one pulse.
- **Simultaneous:** press channels 0 and 3 on the same edge. Expect both `button_OUT` bits and `any_pulse` high in the same single cycle.
- **Reset mid-operation:**
  - Assert `rst` for 1 cycle during REPEAT: all outputs are 0 the next cycle.
  - With the button still held, expect a fresh pulse DEBOUNCE_CYCLES+2 edges after reset deasserts.
